// File: rtl/button_debouncer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer_multi
//  Purpose  : N-channel push-button debouncer. Each channel synchronises a
//             raw button, filters it with a stability counter and produces a
//             clean level, one-cycle press/release pulses and optional
//             hold-to-auto-repeat pulses.
//  Ports    : clk_i        - system clock
//             reset_i      - asynchronous active-low reset
//             btn_i        - raw asynchronous buttons, active-high
//             repeat_en_i  - per-channel auto-repeat enable
//             level_o      - debounced level
//             press_o      - one-cycle pulse on debounced 0->1
//             release_o    - one-cycle pulse on debounced 1->0
//             repeat_o     - one-cycle auto-repeat pulse while held
//             any_press_o  - OR of press_o | repeat_o over all channels
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer_multi #(
    parameter int N_CH       = 5,
    parameter int CNT_W      = 16,
    parameter int STABLE_CNT = 50000,
    parameter int HOLD_CNT   = 25000,
    parameter int REPEAT_CNT = 10000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] btn_i,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            any_press_o
);

    // Terminal values: each counter is cleared when it reaches its last value,
    // so it can never wrap.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } rpt_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       sync_q;
        logic [CNT_W-1:0] stab_q, stab_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             repeat_q, repeat_d;
        logic [CNT_W-1:0] hold_q, hold_d;
        rpt_state_e       state_q, state_d;
        logic             w_sync;
        logic             w_flip;

        assign w_sync = sync_q[1];

        // Stability filter: any sample equal to the current level restarts
        // the window, so only an unbroken run of STABLE_CNT differing samples
        // flips the level.
        always_comb begin
            stab_d    = stab_q;
            level_d   = level_q;
            w_flip    = 1'b0;
            if (w_sync == level_q) begin
                stab_d = '0;
            end else if (stab_q == STABLE_LAST) begin
                stab_d  = '0;
                level_d = w_sync;
                w_flip  = 1'b1;
            end else begin
                stab_d = stab_q + CNT_ONE;
            end
            // Pulses are registered alongside level so they coincide with
            // the first cycle the new level is visible.
            press_d   = w_flip &  w_sync;
            release_d = w_flip & ~w_sync;
        end

        // Auto-repeat FSM. Entry to HOLD is only from a fresh press edge, so
        // re-enabling while held does not resume repeating.
        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            repeat_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    hold_d = '0;
                    if (press_d && repeat_en_i[i]) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (release_d || !repeat_en_i[i]) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d  = ST_RPT;
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d = hold_q + CNT_ONE;
                    end
                end
                ST_RPT: begin
                    if (release_d || !repeat_en_i[i]) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == REPEAT_LAST) begin
                        hold_d   = '0;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d = hold_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                sync_q    <= '0;
                stab_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                hold_q    <= '0;
                state_q   <= ST_IDLE;
            end else begin
                sync_q    <= {sync_q[0], btn_i[i]};
                stab_q    <= stab_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
                hold_q    <= hold_d;
                state_q   <= state_d;
            end
        end

        assign level_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
        assign repeat_o[i]  = repeat_q;
    end

    // OR of registered pulses only, so this output cannot glitch.
    assign any_press_o = |(press_o | repeat_o);

endmodule
`default_nettype wire

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
Parametrised N-channel push-button debouncer that extends our single-channel press pulser. Each channel synchronises a raw button input and filters it with a stability counter. It produces a clean level, a one-cycle press pulse, a one-cycle release pulse, and optional hold-to-auto-repeat pulses. It sits between the board buttons and the control FSMs, replacing per-button instances.

Parameters:
N_CH, 5, number of independent button channels
CNT_W, 16, width of per-channel stability and hold counters
STABLE_CNT, 50000, consecutive cycles the synchronised input must differ from level before level flips (1 <= STABLE_CNT < 2^CNT_W)
HOLD_CNT, 25000, cycles after press before first repeat pulse (1 <= HOLD_CNT < 2^CNT_W)
REPEAT_CNT, 10000, cycles between subsequent repeat pulses (1 <= REPEAT_CNT < 2^CNT_W)

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous active-low reset
btn_i  input  N_CH  raw, asynchronous button inputs, active-high
repeat_en_i  input  N_CH  per-channel auto-repeat enable (synchronous to clk_i)
level_o  output  N_CH  debounced button level
press_o  output  N_CH  one-cycle pulse on debounced 0->1
release_o  output  N_CH  one-cycle pulse on debounced 1->0
repeat_o  output  N_CH  one-cycle auto-repeat pulse while held
any_press_o  output  1  OR of press_o | repeat_o across all channels, same cycle

Behaviour:
- Reset: clk_i is clk_i; reset reset_i is asynchronous, active-low. While reset_i=0, sync flops, counters, level_o, press_o, release_o, repeat_o and any_press_o are all 0. Reset mid-count or mid-hold discards all progress. After release, a held button needs a full STABLE_CNT window to assert.
- Synchroniser: 2-flop chain per channel, sync = second flop.
- Stability counter (per channel), each clock:
  - sync == level_o: counter <= 0.
  - sync != level_o and counter == STABLE_CNT-1: level_o <= sync, counter <= 0.
  - Otherwise: counter <= counter+1.
  - A single bounce sample equal to level_o restarts the window.
- Latency: level_o changes on the (STABLE_CNT+2)th rising edge, counting the first edge that samples the new btn_i value as edge 1, provided btn_i stays stable.
- press_o / release_o: registered, high for exactly the one cycle in which level_o first shows the new value. Never both high at once.
- Auto-repeat: per-channel FSM with states IDLE, HOLD and RPT.
  - IDLE -> HOLD on the level_o 0->1 edge (press cycle); hold counter <= 0.
  - HOLD: hold counter +1 per cycle. When it reaches HOLD_CNT: pulse repeat_o, go to RPT, counter <= 0.
  - RPT: hold counter +1 per cycle. When it reaches REPEAT_CNT: pulse repeat_o, counter <= 0.
  - Pulse timing: with press at edge P, repeat_o pulses at P+HOLD_CNT, then every REPEAT_CNT edges after that.
  - Any state -> IDLE on level_o going 0, or on repeat_en_i=0; counter <= 0. repeat_o is never asserted in the release cycle.
  - repeat_en_i rising while held: the next press edge is required; no repeat without a fresh press.
- Channels are fully independent. Simultaneous events on multiple channels each produce their own pulses in the same cycle. any_press_o is combinational OR of registered pulses, so it is glitch-free.
- Counters never wrap: they are always cleared at their terminal value. Widths are checked by parameter constraints, not at runtime.

Test Plan:
Run all scenarios with STABLE_CNT=4, HOLD_CNT=10, REPEAT_CNT=3, N_CH=2.
1. Clean press: btn_i[0] 0->1, held 20 cycles -> level_o[0] rises on edge 6 (1 press_o pulse, same cycle). repeat_en_i=0, so no repeat_o. Release -> release_o pulse 6 edges later.
2. Bounce: btn_i[0] high 3 cycles, low 1, high 3, low 1, repeated -> level_o, press_o stay 0 throughout. A final steady high gives press exactly 6 edges after its start.
3. Auto-repeat: repeat_en_i[0]=1, press held 30 cycles after press edge P -> repeat_o at P+10, P+13, P+16, ... P+28. Release -> no repeat_o in release cycle.
4. Disable mid-hold: repeat_en_i[0] cleared at P+12 -> no further repeat_o. Re-set at P+14 while held -> still none until a new press.
5. Two channels: btn_i[0] and btn_i[1] rise in the same cycle -> both press_o in the same cycle, any_press_o high for 1 cycle. Staggered by 1 cycle -> any_press_o high for 2 consecutive cycles.
6. Reset mid-operation: reset_i low during counter=2 and during RPT -> all outputs 0 immediately (asynchronously). After reset_i high with btn_i still high -> press_o again after the full 6-edge window.
